// File: rtl/ofm_collector_if.sv
// ofm_collector_if: result stream from the conv kernel (two row ports with
// valid strobes) plus the two-port write bus toward the OFM SRAM.
// master = kernel/SRAM side, slave = the collector.
interface ofm_collector_if #(
  parameter int DATA_W = 25,
  parameter int ADDR_W = 18
);
  logic signed [DATA_W-1:0] ofm_port0;
  logic signed [DATA_W-1:0] ofm_port1;
  logic                     ofm_port0_v;
  logic                     ofm_port1_v;
  logic                     wr0_en;
  logic                     wr1_en;
  logic        [ADDR_W-1:0] wr0_addr;
  logic        [ADDR_W-1:0] wr1_addr;
  logic signed [DATA_W-1:0] wr0_data;
  logic signed [DATA_W-1:0] wr1_data;

  modport master (
    output ofm_port0, ofm_port1, ofm_port0_v, ofm_port1_v,
    input  wr0_en, wr1_en, wr0_addr, wr1_addr, wr0_data, wr1_data
  );

  modport slave (
    input  ofm_port0, ofm_port1, ofm_port0_v, ofm_port1_v,
    output wr0_en, wr1_en, wr0_addr, wr1_addr, wr0_data, wr1_data
  );
endinterface

// File: rtl/ofm_collector.sv
// ofm_collector: turns the conv kernel's tiled (band / tile / row-in-band /
// column) output order into linear OFM SRAM write addresses.
// Optional feature macro OFM_CLIP_EN: when defined, beats outside the valid
// OFM_DIM x OFM_DIM window are not written and the address map is packed
// (row stride OFM_DIM, channel stride OFM_DIM^2); otherwise every beat is
// written with the padded map (row stride TI*TW_N, channel stride
// TI*TW_N*BAND_H*N_BANDS).
module ofm_collector #(
  parameter int DATA_W  = 25,
  parameter int TI      = 16,
  parameter int TW_N    = 4,
  parameter int BAND_H  = 5,
  parameter int N_BANDS = 13,
  parameter int OFM_DIM = 61,
  parameter int ADDR_W  = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cfg_co,
  ofm_collector_if.slave bus,
  output logic       busy,
  output logic       done,
  output logic       proto_err
);

`ifdef OFM_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam int ROW_STRIDE = CLIP_EN ? OFM_DIM : TI * TW_N;
  localparam int CH_STRIDE  = CLIP_EN ? OFM_DIM * OFM_DIM : TI * TW_N * BAND_H * N_BANDS;
  localparam int OW_W   = $clog2(TI + 1);
  localparam int TW_W   = $clog2(TW_N + 1);
  localparam int RB_W   = $clog2(BAND_H + 1);
  localparam int BAND_W = $clog2(N_BANDS + 1);
  localparam int OC_W   = 5;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t state_q, state_d;
  logic [OC_W-1:0]   oc_q, oc_d;
  logic [BAND_W-1:0] band_q, band_d;
  logic [TW_W-1:0]   tw_q, tw_d;
  logic [OW_W-1:0]   ow_q, ow_d;
  logic [RB_W-1:0]   rb_q, rb_d;
  logic [1:0]        cfg_co_q, cfg_co_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              wr0_en_q, wr0_en_d;
  logic              wr1_en_q, wr1_en_d;
  logic [ADDR_W-1:0] wr0_addr_q, wr0_addr_d;
  logic [ADDR_W-1:0] wr1_addr_q, wr1_addr_d;
  logic signed [DATA_W-1:0] wr0_data_q, wr0_data_d;
  logic signed [DATA_W-1:0] wr1_data_q, wr1_data_d;

  logic [31:0]       row0;
  logic [31:0]       col;
  logic              clip0;
  logic              clip1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [1:0]        inc;
  logic [RB_W-1:0]   rb_sum;
  logic [OC_W-1:0]   oc_last;

  // Next-state logic: beat decode, position counters, protocol checks, write bus
  always_comb begin
    state_d    = state_q;
    oc_d       = oc_q;
    band_d     = band_q;
    tw_d       = tw_q;
    ow_d       = ow_q;
    rb_d       = rb_q;
    cfg_co_d   = cfg_co_q;
    err_d      = err_q;
    done_d     = 1'b0;
    wr0_en_d   = 1'b0;
    wr1_en_d   = 1'b0;
    wr0_addr_d = wr0_addr_q;
    wr1_addr_d = wr1_addr_q;
    wr0_data_d = wr0_data_q;
    wr1_data_d = wr1_data_q;
    inc        = 2'd1;
    rb_sum     = '0;
    oc_last    = {cfg_co_q, 3'b111};
    row0       = 32'(band_q) * BAND_H + 32'(rb_q);
    col        = 32'(tw_q) * TI + 32'(ow_q);
    clip0      = CLIP_EN && ((row0 >= OFM_DIM) || (col >= OFM_DIM));
    clip1      = CLIP_EN && ((row0 + 1 >= OFM_DIM) || (col >= OFM_DIM));
    addr0      = ADDR_W'(32'(oc_q) * CH_STRIDE + row0 * ROW_STRIDE + col);
    addr1      = addr0 + ADDR_W'(ROW_STRIDE);

    if (start) begin
      // start overrides everything, including a beat arriving in the same cycle
      state_d  = S_COLLECT;
      oc_d     = '0;
      band_d   = '0;
      tw_d     = '0;
      ow_d     = '0;
      rb_d     = '0;
      cfg_co_d = cfg_co;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.ofm_port0_v || bus.ofm_port1_v) err_d = 1'b1;
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (bus.ofm_port0_v || bus.ofm_port1_v) err_d = 1'b1;
        end
        S_COLLECT: begin
          if (bus.ofm_port1_v && !bus.ofm_port0_v) begin
            err_d = 1'b1;
          end else if (bus.ofm_port0_v) begin
            wr0_en_d = !clip0;
            if (!clip0) begin
              wr0_addr_d = addr0;
              wr0_data_d = bus.ofm_port0;
            end
            if (bus.ofm_port1_v) begin
              if (rb_q == RB_W'(BAND_H - 1)) begin
                err_d = 1'b1;
              end else begin
                inc      = 2'd2;
                wr1_en_d = !clip1;
                if (!clip1) begin
                  wr1_addr_d = addr1;
                  wr1_data_d = bus.ofm_port1;
                end
              end
            end
            if (ow_q == OW_W'(TI - 1)) begin
              ow_d   = '0;
              rb_sum = rb_q + RB_W'(inc);
              if (rb_sum >= RB_W'(BAND_H)) begin
                rb_d = '0;
                if (tw_q == TW_W'(TW_N - 1)) begin
                  tw_d = '0;
                  if (band_q == BAND_W'(N_BANDS - 1)) begin
                    band_d = '0;
                    if (oc_q == oc_last) state_d = S_DONE;
                    else                 oc_d    = oc_q + 1'b1;
                  end else begin
                    band_d = band_q + 1'b1;
                  end
                end else begin
                  tw_d = tw_q + 1'b1;
                end
              end else begin
                rb_d = rb_sum;
              end
            end else begin
              ow_d = ow_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, counters and registered outputs, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      oc_q       <= '0;
      band_q     <= '0;
      tw_q       <= '0;
      ow_q       <= '0;
      rb_q       <= '0;
      cfg_co_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr0_en_q   <= 1'b0;
      wr1_en_q   <= 1'b0;
      wr0_addr_q <= '0;
      wr1_addr_q <= '0;
      wr0_data_q <= '0;
      wr1_data_q <= '0;
    end else begin
      state_q    <= state_d;
      oc_q       <= oc_d;
      band_q     <= band_d;
      tw_q       <= tw_d;
      ow_q       <= ow_d;
      rb_q       <= rb_d;
      cfg_co_q   <= cfg_co_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wr0_en_q   <= wr0_en_d;
      wr1_en_q   <= wr1_en_d;
      wr0_addr_q <= wr0_addr_d;
      wr1_addr_q <= wr1_addr_d;
      wr0_data_q <= wr0_data_d;
      wr1_data_q <= wr1_data_d;
    end
  end

  assign bus.wr0_en   = wr0_en_q;
  assign bus.wr1_en   = wr1_en_q;
  assign bus.wr0_addr = wr0_addr_q;
  assign bus.wr1_addr = wr1_addr_q;
  assign bus.wr0_data = wr0_data_q;
  assign bus.wr1_data = wr1_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign proto_err    = err_q;

endmodule

// File: tb/tb_ofm_collector.sv
// tb_ofm_collector: drives tiled beat sequences (fixed and randomized) into
// ofm_collector and compares every cycle's write bus and error flag against
// addresses computed from loop positions (channel, row, column).
module tb_ofm_collector;
  localparam int DATA_W  = 25;
  localparam int TI      = 16;
  localparam int TW_N    = 4;
  localparam int BAND_H  = 5;
  localparam int N_BANDS = 13;
  localparam int OFM_DIM = 61;
  localparam int ADDR_W  = 18;

`ifdef OFM_CLIP_EN
  localparam bit CLIP        = 1'b1;
  localparam int EXP_WRITES  = 8 * 61 * 61;
  localparam int FIRST_ADDR1 = 61;
`else
  localparam bit CLIP        = 1'b0;
  localparam int EXP_WRITES  = 8 * 65 * 64;
  localparam int FIRST_ADDR1 = 64;
`endif

  localparam int K_IDLE    = 0;
  localparam int K_SINGLE  = 1;
  localparam int K_DUAL    = 2;
  localparam int K_P1ONLY  = 3;
  localparam int K_BADDUAL = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] cfg_co;
  logic       busy;
  logic       done;
  logic       proto_err;

  int   checks = 0;
  int   errors = 0;
  int   doneCount = 0;
  int   writeCount = 0;
  logic expErr;
  bit   firstPending;

  ofm_collector_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ofm_collector #(
    .DATA_W(DATA_W), .TI(TI), .TW_N(TW_N), .BAND_H(BAND_H),
    .N_BANDS(N_BANDS), .OFM_DIM(OFM_DIM), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .cfg_co(cfg_co),
    .bus(bus.slave),
    .busy(busy),
    .done(done),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Tally done pulses and write enables as seen just before each edge
  always @(posedge clk) begin
    if (done) doneCount++;
    writeCount += int'(bus.wr0_en) + int'(bus.wr1_en);
  end

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic int addrOf(input int ch, input int row, input int col);
`ifdef OFM_CLIP_EN
    return ch * OFM_DIM * OFM_DIM + row * OFM_DIM + col;
`else
    return ch * 4160 + row * 64 + col;
`endif
  endfunction

  function automatic logic isClipped(input int row, input int col);
    return CLIP && (row >= OFM_DIM || col >= OFM_DIM);
  endfunction

  function automatic logic [127:0] packWr(input logic en, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    return en ? {84'd0, 1'b1, addr, data} : 128'd0;
  endfunction

  function automatic logic [127:0] allOutputs();
    return {37'd0, bus.wr0_en, bus.wr1_en, busy, done, proto_err,
            bus.wr0_addr, bus.wr1_addr, bus.wr0_data, bus.wr1_data};
  endfunction

  // One clock of stimulus; write bus and error flag checked half a cycle later
  task automatic applyStimulus(input logic st, input logic p0v, input logic p1v,
                               input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                               input logic e0, input int a0, input logic e1, input int a1,
                               input logic errNow);
    start           = st;
    bus.ofm_port0_v = p0v;
    bus.ofm_port1_v = p1v;
    bus.ofm_port0   = d0;
    bus.ofm_port1   = d1;
    if (st) expErr = 1'b0;
    else if (errNow) expErr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("wr0", packWr(bus.wr0_en, bus.wr0_addr, bus.wr0_data), packWr(e0, ADDR_W'(a0), d0));
    checkOutput("wr1", packWr(bus.wr1_en, bus.wr1_addr, bus.wr1_data), packWr(e1, ADDR_W'(a1), d1));
    checkOutput("proto_err", proto_err, expErr);
    start           = 1'b0;
    bus.ofm_port0_v = 1'b0;
    bus.ofm_port1_v = 1'b0;
  endtask

  task automatic driveBeat(input int kind, input int ch, input int row, input int col,
                           input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
    case (kind)
      K_SINGLE:  applyStimulus(0, 1, 0, d0, d1, !isClipped(row, col), addrOf(ch, row, col), 0, 0, 0);
      K_DUAL:    applyStimulus(0, 1, 1, d0, d1, !isClipped(row, col), addrOf(ch, row, col),
                               !isClipped(row + 1, col), addrOf(ch, row + 1, col), 0);
      K_P1ONLY:  applyStimulus(0, 0, 1, d0, d1, 0, 0, 0, 0, 1);
      K_BADDUAL: applyStimulus(0, 1, 1, d0, d1, !isClipped(row, col), addrOf(ch, row, col), 0, 0, 1);
      default:   applyStimulus(0, 0, 0, d0, d1, 0, 0, 0, 0, 0);
    endcase
  endtask

  // Walk channels/bands/tiles in kernel order; optionally abort or restart on the last beat
  task automatic runChannels(input int nCh, input bit randomMode, input int abortCh, input bit startOnLast);
    for (int ch = 0; ch < nCh; ch++) begin
      for (int band = 0; band < N_BANDS; band++) begin
        for (int tw = 0; tw < TW_N; tw++) begin
          int rb;
          if (ch == abortCh && band == 6 && tw == 0) return;
          rb = 0;
          while (rb < BAND_H) begin
            bit dual;
            int kind;
            int step;
            if (randomMode) dual = (rb == BAND_H - 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
            else            dual = (rb < BAND_H - 1);
            kind = dual ? ((rb == BAND_H - 1) ? K_BADDUAL : K_DUAL) : K_SINGLE;
            step = (kind == K_DUAL) ? 2 : 1;
            for (int ow = 0; ow < TI; ow++) begin
              int row;
              int col;
              logic [DATA_W-1:0] d0;
              logic [DATA_W-1:0] d1;
              row = band * BAND_H + rb;
              col = tw * TI + ow;
              if (randomMode) begin
                if ($urandom_range(0, 7) == 0)   driveBeat(K_IDLE, ch, row, col, 0, 0);
                if ($urandom_range(0, 199) == 0) driveBeat(K_P1ONLY, ch, row, col, DATA_W'($urandom), DATA_W'($urandom));
              end
              d0 = DATA_W'($urandom);
              d1 = DATA_W'($urandom);
              if (firstPending) begin
                d0 = 25'd5;
                d1 = 25'd7;
              end
              if (startOnLast && ch == nCh - 1 && band == N_BANDS - 1 && tw == TW_N - 1 &&
                  ow == TI - 1 && rb + step >= BAND_H) begin
                applyStimulus(1, 1, dual, d0, d1, 0, 0, 0, 0, 0);
                return;
              end
              driveBeat(kind, ch, row, col, d0, d1);
              if (firstPending) begin
                firstPending = 1'b0;
                checkOutput("first_addr0", bus.wr0_addr, 0);
                checkOutput("first_data0", bus.wr0_data, 5);
                if (kind == K_DUAL) begin
                  checkOutput("first_addr1", bus.wr1_addr, FIRST_ADDR1);
                  checkOutput("first_data1", bus.wr1_data, 7);
                end
              end
              if (ch == 0 && band == N_BANDS - 1 && tw == TW_N - 1 && row == 64 && ow == TI - 1) begin
`ifdef OFM_CLIP_EN
                checkOutput("corner_en", bus.wr0_en, 0);
`else
                checkOutput("corner_addr", {bus.wr0_en, bus.wr0_addr}, {1'b1, 18'd4159});
`endif
              end
            end
            rb += step;
          end
        end
      end
    end
  endtask

  initial begin
    int baseW;
    int baseD;
    rst_n           = 1'b0;
    start           = 1'b0;
    cfg_co          = 2'd0;
    bus.ofm_port0   = '0;
    bus.ofm_port1   = '0;
    bus.ofm_port0_v = 1'b0;
    bus.ofm_port1_v = 1'b0;
    expErr          = 1'b0;
    firstPending    = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", allOutputs(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", busy, 0);

    // Full 8-channel frame, dual/dual/single per tile
    $display("[TB] full frame, fixed tile pattern");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("busy_after_start", busy, 1);
    baseW = writeCount;
    baseD = doneCount;
    firstPending = 1'b1;
    runChannels(8, 0, -1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("done_pulse", {done, busy}, 2'b10);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("done_count", 128'(doneCount - baseD), 1);
    checkOutput("write_count", 128'(writeCount - baseW), EXP_WRITES);

    // A beat while idle is a protocol error and writes nothing
    applyStimulus(0, 1, 1, 25'd3, 25'd4, 0, 0, 0, 0, 1);
    checkOutput("idle_valid_err", proto_err, 1);

    // Randomized patterns, gaps and injected errors, aborted by reset in channel 3
    $display("[TB] randomized frame with reset in channel 3");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    driveBeat(K_P1ONLY, 0, 0, 0, 25'd9, 25'd11);
    checkOutput("p1_only_err", {proto_err, bus.wr0_en, bus.wr1_en}, 3'b100);
    firstPending = 1'b1;
    runChannels(8, 1, 3, 0);
    #2 rst_n = 1'b0;
    #1 checkOutput("reset_mid", allOutputs(), 0);
    expErr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_hold", allOutputs(), 0);
    #2 rst_n = 1'b1;

    // Fresh frame; start lands on the final beat
    $display("[TB] full frame restarted on its last beat");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    firstPending = 1'b1;
    runChannels(8, 0, -1, 1);
    baseD = doneCount;
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("no_done_after_restart", 128'(doneCount - baseD), 0);
    checkOutput("busy_after_restart", {busy, proto_err}, 2'b10);
    driveBeat(K_DUAL, 0, 0, 0, 25'h1ABCDE, 25'h0F0F0F);
    checkOutput("restart_addr0", {bus.wr0_en, bus.wr0_addr}, {1'b1, 18'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
